// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI-to-register-bus bridge: FSM encoding, header
// rw values and the CPOL/CPHA sample-edge selection.
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HEADER   = 2'd1,
    ST_RD_FETCH = 2'd2,
    ST_DATA     = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Data is sampled on the rising SCK edge when CPOL equals CPHA, otherwise on the falling edge.
  function automatic bit sample_on_rise(input int cpol, input int cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Brings sck/nss/mosi into the clk domain and turns SCK/NSS transitions into
// one-clk event pulses aligned with the synchronised mosi level.
module spi_edge_sync
  import spi_bridge_pkg::*;
#(
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sck,
  input  logic nss,
  input  logic mosi,
  output logic sample_pulse,
  output logic shift_pulse,
  output logic nss_fall,
  output logic nss_rise,
  output logic mosi_s
);

  localparam bit   SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam logic SCK_IDLE    = (CPOL != 0);

  logic [SYNC_STAGES-1:0] sck_sync_q, nss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, nss_prev_q;
  logic                   sck_rise, sck_fall;

  // nss resets as "selected" so releasing reset mid-frame never fakes a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q  <= {SYNC_STAGES{SCK_IDLE}};
      nss_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= SCK_IDLE;
      nss_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], nss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      nss_prev_q  <= nss_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_rise     = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign sck_fall     = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
  assign sample_pulse = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_pulse  = SAMPLE_RISE ? sck_fall : sck_rise;
  assign nss_fall     = ~nss_sync_q[SYNC_STAGES-1] & nss_prev_q;
  assign nss_rise     = nss_sync_q[SYNC_STAGES-1] & ~nss_prev_q;
  assign mosi_s       = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_bus_bridge.sv
// Oversampled SPI slave acting as register-bus master: rw+address header, then an
// unbounded burst of data words with address auto-increment and abort detection.
module spi_bus_bridge
  import spi_bridge_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              nss,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] address_bus,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              read_n,
  output logic              write_n,
  output logic              frame_abort
);

  localparam int HDR_W = ADDR_W + 1;
  localparam int RX_W  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNT_W = $clog2(RX_W + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [RX_W-1:0]   rx_q, rx_d, rx_shifted;
  logic [DATA_W-1:0] tx_q, tx_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              read_n_q, read_n_d, write_n_q, write_n_d;
  logic              abort_q, abort_d, inc_q, inc_d;
  logic              sample_pulse, shift_pulse, nss_fall, nss_rise, mosi_s;

  spi_edge_sync #(
    .CPOL        (CPOL),
    .CPHA        (CPHA),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk          (clk),
    .reset_n      (reset_n),
    .sck          (sck),
    .nss          (nss),
    .mosi         (mosi),
    .sample_pulse (sample_pulse),
    .shift_pulse  (shift_pulse),
    .nss_fall     (nss_fall),
    .nss_rise     (nss_rise),
    .mosi_s       (mosi_s)
  );

  assign rx_shifted = {rx_q[RX_W-2:0], mosi_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    read_n_d  = 1'b1;
    write_n_d = 1'b1;
    abort_d   = 1'b0;
    inc_d     = 1'b0;

    if (inc_q) addr_d = addr_q + 1'b1;

    if (nss_rise) begin
      // Deselect beats any coincident SCK edge; a partially received word is dropped.
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      rx_d      = '0;
      abort_d   = (state_q == ST_HEADER) || (state_q == ST_DATA && bit_cnt_q != '0);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (nss_fall) begin
            state_d   = ST_HEADER;
            bit_cnt_d = '0;
            rx_d      = '0;
            tx_d      = '0;
          end
        end
        ST_HEADER: begin
          if (sample_pulse) begin
            rx_d      = rx_shifted;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(HDR_W - 1)) begin
              bit_cnt_d = '0;
              rx_d      = '0;
              rw_d      = rx_shifted[ADDR_W];
              addr_d    = rx_shifted[ADDR_W-1:0];
              if (rx_shifted[ADDR_W] == RW_READ) begin
                state_d  = ST_RD_FETCH;
                read_n_d = 1'b0;
              end else begin
                state_d = ST_DATA;
              end
            end
          end
        end
        ST_RD_FETCH: begin
          // First clk carries the strobe; rdata is captured on the second.
          if (read_n_q) begin
            tx_d    = rdata;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          // The shift edge before a word's first sample only presents the freshly loaded MSB.
          if (shift_pulse && bit_cnt_q != '0) tx_d = {tx_q[DATA_W-2:0], 1'b0};
          if (sample_pulse) begin
            rx_d      = rx_shifted;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              bit_cnt_d = '0;
              rx_d      = '0;
              if (rw_q == RW_READ) begin
                addr_d   = addr_q + 1'b1;
                read_n_d = 1'b0;
                state_d  = ST_RD_FETCH;
              end else begin
                wdata_d   = rx_shifted[DATA_W-1:0];
                write_n_d = 1'b0;
                inc_d     = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      rw_q      <= RW_WRITE;
      read_n_q  <= 1'b1;
      write_n_q <= 1'b1;
      abort_q   <= 1'b0;
      inc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      read_n_q  <= read_n_d;
      write_n_q <= write_n_d;
      abort_q   <= abort_d;
      inc_q     <= inc_d;
    end
  end

  assign miso        = tx_q[DATA_W-1];
  assign miso_oe     = (state_q != ST_IDLE);
  assign address_bus = addr_q;
  assign wdata       = wdata_q;
  assign read_n      = read_n_q;
  assign write_n     = write_n_q;
  assign frame_abort = abort_q;

endmodule

// File: doc/spi_bus_bridge.md
Name: spi_bus_bridge

Overview:
- Oversampled SPI slave that bridges to the parallel register bus. Generational successor of the SPI slave controller: parametrised address/data width and SPI mode, multi-word bursts with address auto-increment, and abort detection.
- All SPI pins are synchronised into one system clock, so the block has a single clock domain.
- Sits between the board SPI header and the register bus; it is the bus master.

Parameters:
ADDR_W, 7, bus address width; header is 1+ADDR_W bits (rw then address, MSB first)
DATA_W, 8, data word width on SPI and bus
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
SYNC_STAGES, 2, synchroniser flops on sck/nss/mosi (min 2)

Ports:
clk  input  1  system clock, must be at least 8x SCK frequency
reset_n  input  1  asynchronous active-low reset
nss  input  1  slave select, active low
sck  input  1  SPI clock
mosi  input  1  SPI data in
miso  output  1  SPI data out
miso_oe  output  1  high while nss is synchronised low
address_bus  output  ADDR_W  bus address
wdata  output  DATA_W  bus write data
rdata  input  DATA_W  bus read data, valid 1 clk after read_n low
read_n  output  1  one-clk active-low read strobe
write_n  output  1  one-clk active-low write strobe
frame_abort  output  1  one-clk pulse when nss rises mid-word

Behaviour:
- Reset (async, active-low) forces these values, held until release:
  - state IDLE
  - read_n=1, write_n=1, frame_abort=0
  - address_bus=0, wdata=0
  - miso=0, miso_oe=0
  - all counters and shift registers 0
- Synchronise sck, nss and mosi through SYNC_STAGES flops.
  - Sample edge = sck rising if CPOL==CPHA, else falling.
  - Shift edge = the opposite edge.
- miso = tx_shift[DATA_W-1].
  - CPHA=1: the first shift edge of a frame does not shift the register; it only presents the MSB.
  - All other shift edges shift left.
- States: IDLE, HEADER, RD_FETCH, DATA.
  - IDLE: on nss falling go to HEADER; clear bit_cnt; tx_shift=0.
  - HEADER: shift mosi into rx on each sample edge.
    - After bit ADDR_W+1, latch rw=bit0 and address_bus=remaining ADDR_W bits.
    - rw=1: go to RD_FETCH. rw=0: go to DATA.
  - RD_FETCH: drive read_n=0 for one clk; on the next clk load tx_shift<=rdata; go to DATA.
    - Total latency from last header sample edge to tx_shift loaded = 2 clk.
    - This is inside half an SCK period at 8x oversampling, so for CPHA=0 the MSB is valid before the first data sample edge.
  - DATA: count DATA_W sample edges.
    - Write: after the DATA_W-th edge, set wdata=received word and pulse write_n=0 for one clk at the current address. Increment address_bus on the clk after the strobe.
    - Read: after the DATA_W-th edge, increment address_bus and re-enter RD_FETCH (prefetch of the next word). Received mosi bits are ignored.
    - Stay in the DATA/RD_FETCH loop until nss rises. Unbounded burst length.
- Address wrap: address_bus increments modulo 2^ADDR_W (all-ones wraps to 0). No error is flagged.
- nss rising (synchronised), any state: go to IDLE next clk; miso_oe=0; read_n and write_n forced 1.
  - Rising in HEADER, or in DATA with 0 < bit_cnt < DATA_W: pulse frame_abort for one clk. A partial write word is discarded with no write_n.
  - Rising with bit_cnt==0 (word boundary) or in IDLE: no abort.
- Simultaneous events: a sample edge and nss rising in the same clk means nss wins; the edge is discarded.
- nss low with no SCK: stays in HEADER indefinitely, no bus activity.
- read_n and write_n are never low in the same clk. Each strobe lasts exactly one clk.
- Reset mid-frame: immediate return to the reset values; the next frame requires a fresh nss falling edge.

Decomposition:
- Shared package spi_bridge_pkg holds:
  - state encoding constants (IDLE/HEADER/RD_FETCH/DATA)
  - RW_READ=1, RW_WRITE=0
  - edge-select function of CPOL/CPHA
- One natural sub-module: spi_edge_sync, which synchronises sck/nss/mosi and emits one-clk sample_pulse, shift_pulse, nss_fall and nss_rise.

Test Plan:
- Mode 0, defaults, write frame 0x05 then 0xA5 -> one write_n pulse with address_bus=0x05, wdata=0xA5; no read_n; frame_abort stays 0.
- Mode 0, read header 0x85 with rdata=0x3C -> read_n pulse once, miso shifts 0x3C MSB first; address_bus=0x06 after the word.
- Write burst starting at 0x7F with 3 words 0x11, 0x22, 0x33 -> write_n pulses at addresses 0x7F, 0x00, 0x01 with matching data (wrap check).
- Sweep all four CPOL/CPHA combinations with a read of address 0x10 returning 0xC3 -> master captures 0xC3 in every mode.
- nss raised after 4 data bits of a write -> frame_abort pulses once, no write_n; the next full frame works normally.
- Assert reset_n low mid-read-burst -> all outputs take reset values asynchronously; the frame after release reads correctly.
- ADDR_W=10, DATA_W=16, read address 0x3FF with rdata=0xBEEF -> 0xBEEF out on miso; address_bus wraps to 0x000.
